// File: rtl/divider.sv
// divider: multi-cycle 80186 DIV/IDIV unit that sits beside the execute-stage ALU.
// Restoring division, one quotient bit per cycle, MSB first.
//
// Ports:
//   clk, reset_n          core clock, asynchronous active-low reset
//   start                 single-cycle request, sampled only in IDLE
//   is_8_bit              1: dividend[15:0] / divisor[7:0]; 0: dividend[31:0] / divisor[15:0]
//   is_signed             1: IDIV (two's complement), 0: DIV
//   dividend, divisor     operands (DX:AX or AX, and the source operand)
//   quotient, remainder   registered results (AL/AH zero-extended in 8-bit mode)
//   busy                  start | (state != IDLE)
//   complete              one-cycle pulse, result or error valid
//   error                 divide error, valid with complete
module divider (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        complete,
    output logic        error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PREP  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FIXUP = 2'd3;

    logic [1:0]  state;
    logic [31:0] dvd_r;
    logic [15:0] dvs_r;
    logic        is8_r;
    logic        sgn_r;
    logic        neg_q;
    logic        neg_r;
    logic [15:0] rem;    // partial remainder, always < dmag
    logic [15:0] lo;     // dividend bits still to shift in, MSB-aligned
    logic [15:0] q;      // quotient bits, shifted in from the LSB
    logic [15:0] dmag;   // |divisor|
    logic [4:0]  cnt;

    // ---- PREP: magnitudes and signs ----
    logic        dvd_neg, dvs_neg;
    logic [31:0] ad32;
    logic [15:0] ad16, as16;
    logic [7:0]  as8;
    logic [15:0] prep_hi, prep_lo, prep_dvs;
    logic        prep_err;

    assign dvd_neg  = sgn_r & (is8_r ? dvd_r[15] : dvd_r[31]);
    assign dvs_neg  = sgn_r & (is8_r ? dvs_r[7]  : dvs_r[15]);
    assign ad32     = dvd_neg ? (32'd0 - dvd_r)        : dvd_r;
    assign ad16     = dvd_neg ? (16'd0 - dvd_r[15:0])  : dvd_r[15:0];
    assign as16     = dvs_neg ? (16'd0 - dvs_r)        : dvs_r;
    assign as8      = dvs_neg ? (8'd0 - dvs_r[7:0])    : dvs_r[7:0];
    assign prep_hi  = is8_r ? {8'd0, ad16[15:8]} : ad32[31:16];
    assign prep_lo  = is8_r ? {ad16[7:0], 8'd0}  : ad32[15:0];
    assign prep_dvs = is8_r ? {8'd0, as8}        : as16;
    // Upper half >= divisor means the quotient cannot fit in n bits.
    assign prep_err = (prep_dvs == 16'd0) || (prep_hi >= prep_dvs);

    // ---- RUN: one restoring step ----
    logic [16:0] shifted;
    logic        fits;
    logic [15:0] diff;

    assign shifted = {rem, lo[15]};
    assign fits    = shifted >= {1'b0, dmag};
    // The difference is below dmag when it fits, so 16 bits are enough.
    assign diff    = shifted[15:0] - dmag;

    // ---- FIXUP: sign correction and range check ----
    logic [15:0] qmag, limit, q_fix, r_fix;
    logic        range_err;

    assign qmag      = is8_r ? {8'd0, q[7:0]} : q;
    assign limit     = is8_r ? 16'h0080 : 16'h8000;
    // Most-negative quotient is legal, its positive twin is not.
    assign range_err = sgn_r & (neg_q ? (qmag > limit) : (qmag >= limit));
    assign q_fix     = neg_q ? (16'd0 - qmag) : qmag;
    assign r_fix     = neg_r ? (16'd0 - rem)  : rem;

    assign busy = start | (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dvd_r     <= '0;
            dvs_r     <= '0;
            is8_r     <= 1'b0;
            sgn_r     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem       <= '0;
            lo        <= '0;
            q         <= '0;
            dmag      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            complete  <= 1'b0;
            error     <= 1'b0;
        end else begin
            complete <= 1'b0;
            error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                        is8_r <= is_8_bit;
                        sgn_r <= is_signed;
                        state <= PREP;
                    end
                end
                PREP: begin
                    neg_q <= dvd_neg ^ dvs_neg;
                    neg_r <= dvd_neg;
                    if (prep_err) begin
                        complete <= 1'b1;
                        error    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rem   <= prep_hi;
                        lo    <= prep_lo;
                        dmag  <= prep_dvs;
                        q     <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem <= fits ? diff : shifted[15:0];
                    q   <= {q[14:0], fits};
                    lo  <= {lo[14:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == (is8_r ? 5'd7 : 5'd15))
                        state <= FIXUP;
                end
                default: begin  // FIXUP
                    complete <= 1'b1;
                    state    <= IDLE;
                    if (range_err) begin
                        error <= 1'b1;
                    end else begin
                        quotient  <= is8_r ? {8'd0, q_fix[7:0]} : q_fix;
                        remainder <= is8_r ? {8'd0, r_fix[7:0]} : r_fix;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: hand-computed vectors, latency, error path,
// back-to-back issue, ignored mid-run start and asynchronous reset abort.
module tb_divider;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        complete;
    logic        error;

    int total = 0;
    int bad   = 0;

    divider dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_8_bit  (is_8_bit),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .complete  (complete),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an operation in the current cycle C, return in the complete cycle.
    // lat = cycles from C to complete. glitch>0 pulses start with junk at C+glitch.
    task automatic run_op(input logic b8, input logic sg, input logic [31:0] dd,
                          input logic [15:0] ds, input int glitch, output int lat);
        int k;
        is_8_bit  = b8;
        is_signed = sg;
        dividend  = dd;
        divisor   = ds;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 16'h0000;
        k = 1;
        while (!complete && k < 40) begin
            if (k == glitch) begin
                start     = 1'b1;
                is_8_bit  = 1'b1;
                is_signed = 1'b0;
                dividend  = 32'h0000_0100;
                divisor   = 16'h0001;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        lat = k;
    endtask

    task automatic op(input string tag, input logic b8, input logic sg,
                      input logic [31:0] dd, input logic [15:0] ds, input int glitch,
                      input int exp_lat, input logic exp_err,
                      input logic [15:0] exp_q, input logic [15:0] exp_r);
        int lat;
        run_op(b8, sg, dd, ds, glitch, lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " complete"}, {31'd0, complete}, 32'd1);
        check({tag, " error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " quotient"}, {16'd0, quotient}, {16'd0, exp_q});
        check({tag, " remainder"}, {16'd0, remainder}, {16'd0, exp_r});
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_8_bit  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", {16'd0, quotient}, 32'd0);
        check("reset remainder", {16'd0, remainder}, 32'd0);
        check("reset complete", {31'd0, complete}, 32'd0);
        check("reset error", {31'd0, error}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 65536 / 3 = 21845 r 1
        op("div16", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, 0, 19, 1'b0, 16'h5555, 16'h0001);
        tick();
        // -7 / 2 = -3 r -1
        op("idiv8", 1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, 0, 11, 1'b0, 16'h00FD, 16'h00FF);
        tick();
        // divide by zero: results untouched
        op("div0_16", 1'b0, 1'b0, 32'h0000_1234, 16'h0000, 0, 2, 1'b1, 16'h00FD, 16'h00FF);
        tick();
        check("complete one cycle", {31'd0, complete}, 32'd0);
        check("error one cycle", {31'd0, error}, 32'd0);
        // 255 / 16 = 15 r 15
        op("div8", 1'b1, 1'b0, 32'h0000_00FF, 16'h0010, 0, 11, 1'b0, 16'h000F, 16'h000F);
        tick();
        // upper half equals divisor -> early overflow
        op("ovf_div16", 1'b0, 1'b0, 32'h0002_0000, 16'h0002, 0, 2, 1'b1, 16'h000F, 16'h000F);
        tick();
        // +32768 does not fit a signed 16-bit quotient -> late error
        op("ovf_idiv16", 1'b0, 1'b1, 32'h0000_8000, 16'h0001, 0, 19, 1'b1, 16'h000F, 16'h000F);
        tick();
        // -32768 / 1 is legal
        op("idiv16_min", 1'b0, 1'b1, 32'hFFFF_8000, 16'h0001, 0, 19, 1'b0, 16'h8000, 16'h0000);
        tick();
        op("div0_8", 1'b1, 1'b0, 32'h0000_0040, 16'h0000, 0, 2, 1'b1, 16'h8000, 16'h0000);
        tick();
        // 100 / -7 = -14 r 2, with a start pulse mid-RUN that must be ignored
        op("idiv16_glitch", 1'b0, 1'b1, 32'h0000_0064, 16'hFFF9, 5, 19, 1'b0, 16'hFFF2, 16'h0002);
        tick();
        // back-to-back: second start issued in the first complete cycle
        op("b2b_first", 1'b1, 1'b0, 32'h0000_0064, 16'h000A, 0, 11, 1'b0, 16'h000A, 16'h0000);
        // -100 / 7 = -14 r -2
        op("b2b_second", 1'b0, 1'b1, 32'hFFFF_FF9C, 16'h0007, 0, 19, 1'b0, 16'hFFF2, 16'hFFFE);
        tick();

        // reset in C+5 of a 16-bit DIV
        is_8_bit  = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0001_0000;
        divisor   = 16'h0003;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("abort quotient", {16'd0, quotient}, 32'd0);
        check("abort remainder", {16'd0, remainder}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort complete", {31'd0, complete}, 32'd0);
        seen = 0;
        repeat (3) begin
            tick();
            if (complete) seen++;
        end
        reset_n = 1'b1;
        repeat (20) begin
            tick();
            if (complete) seen++;
        end
        check("abort no complete", seen, 0);
        check("abort idle busy", {31'd0, busy}, 32'd0);
        op("after_reset", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, 0, 19, 1'b0, 16'h5555, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
